fir_interp_mac: RTL and testbench
=================================

# fir_interp_mac

Time-multiplexed polyphase interpolating FIR filter: accepts one 17-bit signed sample through a valid/ready handshake and emits L=2 filtered output samples, each computed with a single shared multiplier-accumulator over P=4 taps. It is the upsampling counterpart of the serial single-rate MAC FIR. It sits on the transmit path between a sample source at rate Fs and a consumer at L·Fs, running on a fast clock gated by a clock-enable.

## Interface
- DW_IN, 17, input sample width (signed)
- CW, 6, coefficient width (signed)
- L, 2, interpolation factor (number of phases)
- P, 4, taps per phase; total taps N = L·P = 8
- DW_OUT, DW_IN+CW+$clog2(P) = 25, output width (signed, full precision)
- i_clk  in  1  clock, all logic on rising edge
- i_rst_an  in  1  reset, synchronous, active-low
- i_ena  in  1  clock enable; all registers hold when low
- i_valid  in  1  input sample valid
- i_data  in  DW_IN  input sample, signed
- o_ready  out  1  block can accept a sample
- o_valid  out  1  o_data holds a new output sample
- o_data  out  DW_OUT  output sample, signed

## Operation
- Coefficients h[0..7] = {-1, 0, 9, 16, 16, 9, 0, -1}, constant, signed CW bits.
- Delay line dl[0..P-1], dl[0] newest. Output y[L·n+ph] = Σ_{j=0..P-1} h[j·L+ph]·dl[j], ph = 0..L-1.
- FSM, two states:
  - IDLE: o_ready=1. Enabled edge with i_valid=1: dl shifts (dl[0]<=i_data, dl[j]<=dl[j-1]), acc<=0, ph<=0, tap<=0, go RUN. i_valid=0: stay.
  - RUN: o_ready=0. Each enabled edge: acc += dl[tap]·h[tap·L+ph]. When tap==P-1: o_data <= acc + current product, o_valid<=1, acc<=0, tap<=0; if ph==L-1 go IDLE, else ph<=ph+1. Otherwise tap<=tap+1.
- i_valid while o_ready=0 is ignored; sample is not captured (source must hold it).
- o_valid is registered: set on the edge that writes o_data, cleared on the next enabled edge. o_data holds its last value between outputs.
- Arithmetic: product DW_IN+CW = 23 bits, sign-extended into DW_OUT accumulator; no saturation or rounding (cannot overflow for the given coefficients).
- Reset (i_rst_an=0 at an edge, regardless of i_ena): state IDLE, dl all 0, acc 0, ph/tap 0, o_valid 0, o_data 0. Reset mid-RUN abandons the computation; no partial output is emitted.

## Timing
- Reset values: o_ready=1, o_valid=0, o_data=0.
- Count enabled edges from the accept edge = E0. MAC edges E1..E4 (phase 0), output 0 written at E4, o_valid=1 during the cycle after E4. Phase 1 MACs E5..E8, output 1 written at E8, state returns IDLE at E8.
- o_ready=1 after E8; earliest next accept is E9. Throughput is one input per L·P+1 = 9 enabled cycles.
- i_ena low: no state, counter, delay line, or output change; o_valid holds its level. Consumers qualify o_valid with i_ena.

## Structure
- Shared package fir_pkg: DW_IN, CW, DW_OUT defaults, coefficient array type, and the h[] constant (shared with the single-rate MAC filter).
- Sub-module fir_interp_ctrl: FSM plus ph/tap counters; outputs o_ready, tap, ph, acc_clr, out_we. Datapath (delay line, coefficient mux, multiplier, accumulator, output register) stays in the top.

## Test plan
- Impulse: i_data=1, then 3 samples of 0, i_ena=1 -> o_data sequence -1, 0, 9, 16, 16, 9, 0, -1, each with a one-cycle o_valid pulse; output pair spacing is 9 cycles per input.
- DC: i_data=1000 for 6 samples -> from the 4th input onward both phases output 24000.
- Negative full scale: i_data=-65536 steady -> settled outputs -1572864 on both phases, with no wrap.
- Backpressure/busy: i_valid held high continuously with changing data -> a sample is accepted only on edges where o_ready=1 (every 9th cycle). Data presented while o_ready=0 is never used.
- Enable gating: toggle i_ena 1-0-1 every cycle during RUN -> identical output values to the i_ena=1 run, with all timing stretched; o_valid stays high for exactly one enabled cycle.
- Reset mid-operation: assert i_rst_an=0 at E3 for one cycle -> o_valid stays 0 and o_ready=1 after reset. A following impulse reproduces the clean impulse response, because the delay line was cleared.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR constants: widths, the 8-tap half-band-style coefficient set,
// the controller state type and the polyphase coefficient lookup.
package fir_pkg;

    localparam int DW_IN  = 17;
    localparam int CW     = 6;
    localparam int L      = 2;
    localparam int P      = 4;
    localparam int N      = L * P;
    localparam int PW     = DW_IN + CW;
    localparam int DW_OUT = PW + $clog2(P);
    localparam int TAP_W  = $clog2(P);
    localparam int PH_W   = (L > 1) ? $clog2(L) : 1;
    localparam int IDX_W  = $clog2(N);

    typedef logic signed [CW-1:0] coef_t;
    typedef logic [N-1:0][CW-1:0] coef_arr_t;

    // Packed array: the leftmost element is h[N-1], the rightmost is h[0].
    localparam coef_arr_t H = {-6'sd1, 6'sd0, 6'sd9, 6'sd16,
                               6'sd16, 6'sd9, 6'sd0, -6'sd1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fir_state_e;

    // Phase ph of the polyphase split uses h[tap*L + ph].
    function automatic coef_t coef_at(input logic [TAP_W-1:0] tap,
                                      input logic [PH_W-1:0]  ph);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(tap) * IDX_W'(L) + IDX_W'(ph);
        return $signed(H[idx]);
    endfunction

endpackage

// File: rtl/fir_interp_mac_if.sv
// Sample stream into the interpolator and filtered stream out of it.
interface fir_interp_mac_if;
    import fir_pkg::*;

    // Input side: a sample transfers on an enabled edge with i_valid=1 and
    // o_ready=1; while o_ready=0 the source must hold i_data/i_valid.
    // Output side: o_valid is a one-enabled-cycle pulse with no back-pressure.
    logic                     i_valid;
    logic signed [DW_IN-1:0]  i_data;
    logic                     o_ready;
    logic                     o_valid;
    logic signed [DW_OUT-1:0] o_data;

    modport master (output i_valid, output i_data,
                    input  o_ready, input  o_valid, input o_data);
    modport slave  (input  i_valid, input  i_data,
                    output o_ready, output o_valid, output o_data);

endinterface

// File: rtl/fir_interp_ctrl.sv
// Sequencer for the shared MAC: walks P taps for each of the L phases after
// every accepted sample, then returns to IDLE to take the next one.
module fir_interp_ctrl
    import fir_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_an,
    input  logic             i_ena,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [TAP_W-1:0] tap,
    output logic [PH_W-1:0]  ph,
    output logic             acc_clr,
    output logic             out_we,
    output fir_state_e       state
);

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(P - 1);
    localparam logic [TAP_W-1:0] TAP_PRE  = TAP_W'(P - 2);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(L - 1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            state   <= ST_IDLE;
            o_ready <= 1'b1;
            tap     <= '0;
            ph      <= '0;
            out_we  <= 1'b0;
        end else if (i_ena) begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        state   <= ST_RUN;
                        o_ready <= 1'b0;
                        tap     <= '0;
                        ph      <= '0;
                    end
                end
                ST_RUN: begin
                    if (tap == TAP_LAST) begin
                        tap    <= '0;
                        out_we <= 1'b0;
                        if (ph == PH_LAST) begin
                            state   <= ST_IDLE;
                            o_ready <= 1'b1;
                        end else begin
                            ph <= ph + PH_W'(1);
                        end
                    end else begin
                        tap <= tap + TAP_W'(1);
                        // Flag the last tap one edge ahead so the write strobe is registered.
                        out_we <= (tap == TAP_PRE);
                    end
                end
            endcase
        end
    end

    // The accumulator restarts from zero while idle and after every output write.
    assign acc_clr = o_ready | out_we;

endmodule

// File: rtl/fir_interp_mac.sv
// Polyphase L=2 interpolating FIR with one shared multiplier-accumulator:
// each accepted sample yields two full-precision outputs, four MACs apiece.
module fir_interp_mac
    import fir_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_an,
    input  logic              i_ena,
    fir_interp_mac_if.slave   bus,
    output fir_state_e        o_dbg_state
);

    logic [TAP_W-1:0]         tap;
    logic [PH_W-1:0]          ph;
    logic                     acc_clr;
    logic                     out_we;
    logic                     load;
    logic signed [DW_IN-1:0]  dl [P];
    logic signed [DW_IN-1:0]  dl_sel;
    coef_t                    coef;
    logic signed [PW-1:0]     prod;
    logic signed [DW_OUT-1:0] acc;
    logic signed [DW_OUT-1:0] mac_sum;

    fir_interp_ctrl u_ctrl (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_ena    (i_ena),
        .i_valid  (bus.i_valid),
        .o_ready  (bus.o_ready),
        .tap      (tap),
        .ph       (ph),
        .acc_clr  (acc_clr),
        .out_we   (out_we),
        .state    (o_dbg_state)
    );

    assign load    = bus.o_ready & bus.i_valid;
    assign dl_sel  = dl[tap];
    assign coef    = coef_at(tap, ph);
    assign prod    = PW'(dl_sel) * PW'(coef);
    assign mac_sum = acc + DW_OUT'(prod);

    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            dl          <= '{default: '0};
            acc         <= '0;
            bus.o_data  <= '0;
            bus.o_valid <= 1'b0;
        end else if (i_ena) begin
            bus.o_valid <= out_we;
            acc         <= acc_clr ? '0 : mac_sum;
            // The final product goes straight into the output, not through acc.
            if (out_we) begin
                bus.o_data <= mac_sum;
            end
            if (load) begin
                dl[0] <= bus.i_data;
                for (int j = 1; j < P; j++) begin
                    dl[j] <= dl[j-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_interp_mac.sv
// Bench for fir_interp_mac: directed scenarios plus random traffic, checked
// every cycle against a sample-level model of the interpolator.
module tb_fir_interp_mac;
    import fir_pkg::*;

    logic       clk;
    logic       rst_an;
    logic       ena;
    fir_state_e dbg_state;

    fir_interp_mac_if bus ();

    fir_interp_mac dut (
        .i_clk       (clk),
        .i_rst_an    (rst_an),
        .i_ena       (ena),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- counters and queues ----------------
    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    logic signed [DW_OUT-1:0] exp_q[$];
    logic signed [DW_OUT-1:0] obs_q[$];
    logic signed [DW_OUT-1:0] exp_head;

    int h [8] = '{-1, 0, 9, 16, 16, 9, 0, -1};
    int imp [8] = '{-1, 0, 9, 16, 16, 9, 0, -1};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, $signed(got), $signed(want), $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One accepted sample produces y[ph] = sum_j h[j*L+ph]*x[n-j]; the pair
    // appears 4 and 8 enabled edges after the accept, ready returns after 8.
    int  hist [4];
    int  y_pend [2];
    int  busy = 0;
    bit  exp_valid = 1'b0;
    bit  exp_ready = 1'b1;
    logic signed [DW_OUT-1:0] exp_data = '0;
    bit  edge_en = 1'b0;
    bit  started = 1'b0;

    function automatic int model_y(input int ph);
        int s = 0;
        for (int j = 0; j < 4; j++) s += h[j*2+ph] * hist[j];
        return s;
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_an) begin
            busy      = 0;
            for (int j = 0; j < 4; j++) hist[j] = 0;
            exp_valid = 1'b0;
            exp_ready = 1'b1;
            exp_data  = '0;
            exp_q.delete();
            edge_en   = 1'b0;
        end else if (ena) begin
            edge_en   = 1'b1;
            exp_valid = 1'b0;
            if (busy == 0) begin
                if (bus.i_valid) begin
                    for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
                    hist[0] = int'(bus.i_data);
                    y_pend[0] = model_y(0);
                    y_pend[1] = model_y(1);
                    exp_q.push_back(DW_OUT'(y_pend[0]));
                    exp_q.push_back(DW_OUT'(y_pend[1]));
                    busy = 8;
                    acc_cnt++;
                end
            end else begin
                busy--;
                if (busy == 4) begin
                    exp_valid = 1'b1;
                    exp_data  = DW_OUT'(y_pend[0]);
                end else if (busy == 0) begin
                    exp_valid = 1'b1;
                    exp_data  = DW_OUT'(y_pend[1]);
                end
            end
            exp_ready = (busy == 0);
        end else begin
            edge_en = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("o_ready", 32'(bus.o_ready), 32'(exp_ready));
            chk("o_valid", 32'(bus.o_valid), 32'(exp_valid));
            chk("o_data", 32'(bus.o_data), 32'(exp_data));
            chk("dbg_state", 32'(dbg_state), exp_ready ? 32'(ST_IDLE) : 32'(ST_RUN));
            if (edge_en && bus.o_valid === 1'b1) begin
                obs_q.push_back(bus.o_data);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_seq: got unexpected output %0d want none at %0t",
                             bus.o_data, $time);
                end else begin
                    exp_head = exp_q.pop_front();
                    chk("out_seq", 32'(bus.o_data), 32'(exp_head));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // mode 0: enable high, 1: enable toggles every cycle, 2: random enable
    task automatic tick(input int mode);
        @(posedge clk);
        #1;
        case (mode)
            1:       ena = ~ena;
            2:       ena = ($urandom_range(0, 3) != 0);
            default: ena = 1'b1;
        endcase
    endtask

    task automatic do_reset();
        rst_an      = 1'b0;
        bus.i_valid = 1'b0;
        tick(0);
        tick(0);
        rst_an = 1'b1;
        obs_q.delete();
    endtask

    task automatic send(input int d, input int mode);
        int n0;
        n0 = acc_cnt;
        bus.i_valid = 1'b1;
        bus.i_data  = 17'(d);
        for (int k = 0; k < 100 && acc_cnt == n0; k++) tick(mode);
        bus.i_valid = 1'b0;
        if (acc_cnt == n0) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept want accept of %0d", d);
        end
    endtask

    task automatic drain(input int n, input int mode);
        repeat (n) tick(mode);
        ena = 1'b1;
    endtask

    task automatic chk_obs(input string nm, input int idx, input int want);
        if (obs_q.size() > idx) begin
            chk(nm, 32'(obs_q[idx]), 32'(want));
        end else begin
            total++;
            bad++;
            $display("FAIL %s: got missing output %0d want %0d", nm, idx, want);
        end
    endtask

    task automatic impulse(input int mode, input string nm);
        send(1, mode);
        repeat (3) send(0, mode);
        drain(30, mode);
        for (int i = 0; i < 8; i++) chk_obs(nm, i, imp[i]);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int n0;
        ena         = 1'b1;
        rst_an      = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;

        do_reset();
        chk("reset_ready", 32'(bus.o_ready), 32'd1);
        chk("reset_valid", 32'(bus.o_valid), 32'd0);
        chk("reset_data", 32'(bus.o_data), 32'd0);

        impulse(0, "impulse");

        do_reset();
        repeat (6) send(1000, 0);
        drain(12, 0);
        for (int i = 6; i < 12; i++) chk_obs("dc", i, 24000);

        do_reset();
        repeat (6) send(-65536, 0);
        drain(12, 0);
        for (int i = 6; i < 12; i++) chk_obs("neg_fs", i, -1572864);

        do_reset();
        n0 = acc_cnt;
        bus.i_valid = 1'b1;
        for (int k = 0; k < 45; k++) begin
            bus.i_data = 17'($urandom);
            tick(0);
        end
        bus.i_valid = 1'b0;
        chk("bp_accepts", 32'(acc_cnt - n0), 32'd5);
        drain(12, 0);

        do_reset();
        impulse(1, "ena_gated");

        do_reset();
        send(7, 0);
        tick(0);
        tick(0);
        rst_an = 1'b0;
        tick(0);
        rst_an = 1'b1;
        drain(12, 0);
        chk("mid_reset_outputs", 32'(obs_q.size()), 32'd0);
        chk("mid_reset_ready", 32'(bus.o_ready), 32'd1);
        impulse(0, "post_reset_impulse");

        do_reset();
        for (int k = 0; k < 250; k++) begin
            bus.i_valid = ($urandom_range(0, 1) == 1);
            bus.i_data  = 17'($urandom);
            tick(2);
        end
        bus.i_valid = 1'b0;
        drain(20, 0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
